led_pattern_driver: RTL

//   Parametrised multi-channel LED driver, successor to the single-mode counter flasher.

---
 rtl/led_drv_pkg.sv | 13 +
 rtl/led_prescaler.sv | 31 +++
 rtl/led_pattern_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/led_drv_pkg.sv
// Purpose : shared mode encoding for the LED pattern driver family.
// Latency : n/a (types only).
// Backpressure: n/a.
package led_drv_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/led_prescaler.sv
// Purpose : free-running W-bit prescaler producing a one-cycle step strobe.
// Latency : tick is combinational from the count register (asserted while count is all ones).
// Backpressure: none; enable=0 freezes the count and forces tick low.
//
// Ports:
//   clk          system clock
//   USER_RESET_N asynchronous active-low reset, clears the count
//   enable       1 = count, 0 = hold
//   tick         strobe on the terminal count while enabled
module led_prescaler #(
    parameter int W = 23
) (
    input  logic clk,
    input  logic USER_RESET_N,
    input  logic enable,
    output logic tick
);

    logic [W-1:0] presc;

    always_ff @(posedge clk or negedge USER_RESET_N) begin
        if (!USER_RESET_N) begin
            presc <= '0;
        end else if (enable) begin
            presc <= presc + W'(1);
        end
    end

    assign tick = enable & (&presc);

endmodule

// File: rtl/led_pattern_driver.sv
// Purpose : multi-channel LED driver: COUNT / BLINK / SCAN / BREATHE patterns stepped by a prescaled tick.
// Latency : LED is registered; a step shows one clk after its tick edge (BREATHE: one clk after each pwm edge).
// Backpressure: none; enable=0 freezes prescaler, step state and pwm, LED holds its last value.
//
// Ports:
//   clk          system clock
//   USER_RESET_N asynchronous active-low reset
//   enable       1 = run, 0 = freeze
//   mode         requested pattern, sampled only on tick edges
//   tick         one-cycle step strobe
//   LED          registered LED drive, 1 = on
module led_pattern_driver
    import led_drv_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PRESCALE_W = 23,
    parameter int PWM_W      = 8
) (
    input  logic                clk,
    input  logic                USER_RESET_N,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic                tick,
    output logic [NUM_LEDS-1:0] LED
);

    mode_t               mode_q, mode_nxt;
    logic                mode_chg;
    logic [NUM_LEDS-1:0] step_q, step_nxt;
    logic [NUM_LEDS-1:0] pos_q, pos_nxt;
    logic                dir_up_q, dir_up_nxt;
    logic [PWM_W-1:0]    duty_q, duty_nxt;
    logic                ramp_up_q, ramp_up_nxt;
    logic [PWM_W-1:0]    pwm_q;
    logic [NUM_LEDS-1:0] led_nxt;

    led_prescaler #(.W(PRESCALE_W)) u_presc (
        .clk          (clk),
        .USER_RESET_N (USER_RESET_N),
        .enable       (enable),
        .tick         (tick)
    );

    // State register
    always_ff @(posedge clk or negedge USER_RESET_N) begin
        if (!USER_RESET_N) begin
            mode_q    <= MODE_COUNT;
            step_q    <= '0;
            pos_q     <= NUM_LEDS'(1);
            dir_up_q  <= 1'b1;
            duty_q    <= '0;
            ramp_up_q <= 1'b1;
            pwm_q     <= '0;
            LED       <= '0;
        end else begin
            mode_q    <= mode_nxt;
            step_q    <= step_nxt;
            pos_q     <= pos_nxt;
            dir_up_q  <= dir_up_nxt;
            duty_q    <= duty_nxt;
            ramp_up_q <= ramp_up_nxt;
            LED       <= led_nxt;
            if (enable) begin
                pwm_q <= pwm_q + PWM_W'(1);
            end
        end
    end

    // Next-state: all step state moves only on tick edges
    always_comb begin
        mode_nxt    = mode_q;
        step_nxt    = step_q;
        pos_nxt     = pos_q;
        dir_up_nxt  = dir_up_q;
        duty_nxt    = duty_q;
        ramp_up_nxt = ramp_up_q;
        mode_chg    = tick && (mode_t'(mode) != mode_q);

        if (tick) begin
            mode_nxt = mode_t'(mode);
            if (mode_chg) begin
                // Entering a new pattern always starts it from its origin
                step_nxt    = '0;
                pos_nxt     = NUM_LEDS'(1);
                dir_up_nxt  = 1'b1;
                duty_nxt    = '0;
                ramp_up_nxt = 1'b1;
            end else begin
                case (mode_q)
                    MODE_COUNT: step_nxt = step_q + NUM_LEDS'(1);
                    MODE_SCAN: begin
                        if (NUM_LEDS > 1) begin
                            pos_nxt = dir_up_q ? (pos_q << 1) : (pos_q >> 1);
                            // Turn around on arrival so the end position is not shown twice
                            if (pos_nxt[NUM_LEDS-1]) begin
                                dir_up_nxt = 1'b0;
                            end else if (pos_nxt[0]) begin
                                dir_up_nxt = 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        duty_nxt = ramp_up_q ? (duty_q + PWM_W'(1)) : (duty_q - PWM_W'(1));
                        if (ramp_up_q && (duty_nxt == {PWM_W{1'b1}})) begin
                            ramp_up_nxt = 1'b0;
                        end else if (!ramp_up_q && (duty_nxt == '0)) begin
                            ramp_up_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output: single LED mux; BREATHE refreshes every enabled clk against the duty in force
    always_comb begin
        led_nxt = LED;
        if (enable) begin
            if (mode_nxt == MODE_BREATHE) begin
                led_nxt = {NUM_LEDS{pwm_q < duty_nxt}};
            end else if (tick) begin
                case (mode_nxt)
                    MODE_COUNT: led_nxt = step_nxt;
                    MODE_BLINK: led_nxt = mode_chg ? {NUM_LEDS{1'b1}} : ~LED;
                    MODE_SCAN:  led_nxt = pos_nxt;
                    default:    led_nxt = LED;
                endcase
            end
        end
    end

endmodule
